// File: rtl/edsac_pkg.sv
// rtl/edsac_pkg.sv - shared slot index type and per-word mode encoding for the serial counter
package edsac_pkg;

    localparam int MAX_WIDTH = 64;

    // Wide enough for any legal word length; unused upper bits stay zero.
    typedef logic [$clog2(MAX_WIDTH)-1:0] slot_t;

    typedef enum logic [2:0] {
        MODE_IDLE = 3'd0,
        MODE_INC  = 3'd1,
        MODE_DEC  = 3'd2,
        MODE_LOAD = 3'd3,
        MODE_CLR  = 3'd4
    } mode_t;

    // Clear beats load, load beats counting.
    function automatic mode_t decode_mode(
        input logic i_inc_en,
        input logic i_dec,
        input logic i_load,
        input logic i_clr_neg
    );
        if (!i_clr_neg)
            return MODE_CLR;
        else if (i_load)
            return MODE_LOAD;
        else if (i_inc_en)
            return i_dec ? MODE_DEC : MODE_INC;
        else
            return MODE_IDLE;
    endfunction

endpackage

// File: rtl/delay_line.sv
// rtl/delay_line.sv - INTERVAL-cycle single-bit delay; i_sync realigns the tap to position 0
module delay_line #(
    parameter int          INTERVAL = 1,
    parameter logic [63:0] INIT     = 64'd0
) (
    input  logic clk,
    input  logic reset_neg,
    input  logic i_sync,
    input  logic i_din,
    output logic o_dout
);

    localparam int                  PW       = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [PW-1:0]       LAST_PTR = PW'(INTERVAL - 1);
    localparam logic [INTERVAL-1:0] ONE_HOT0 = INTERVAL'(1);

    logic [INTERVAL-1:0] r_mem;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       w_ptr;
    logic [INTERVAL-1:0] w_tap;
    logic [INTERVAL-1:0] w_mask;

    // Read-before-write at the same position yields the bit written INTERVAL cycles ago.
    assign w_ptr  = i_sync ? '0 : r_ptr;
    assign w_tap  = r_mem >> w_ptr;
    assign o_dout = w_tap[0];
    assign w_mask = ONE_HOT0 << w_ptr;

    always_ff @(posedge clk or negedge reset_neg) begin
        if (!reset_neg) begin
            r_mem <= INIT[INTERVAL-1:0];
            r_ptr <= '0;
        end else begin
            r_mem <= (r_mem & ~w_mask) | (i_din ? w_mask : '0);
            r_ptr <= (w_ptr == LAST_PTR) ? '0 : w_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/serial_full_adder.sv
// rtl/serial_full_adder.sv - one full-adder step per cycle with a registered carry
module serial_full_adder (
    input  logic clk,
    input  logic reset_neg,
    input  logic i_a,
    input  logic i_b,
    input  logic i_preset,
    input  logic i_preset_val,
    output logic o_sum,
    output logic o_cout
);

    logic r_carry;
    logic w_cin;

    assign w_cin  = i_preset ? i_preset_val : r_carry;
    assign o_sum  = i_a ^ i_b ^ w_cin;
    assign o_cout = (i_a & i_b) | (w_cin & (i_a ^ i_b));

    always_ff @(posedge clk or negedge reset_neg) begin
        if (!reset_neg)
            r_carry <= 1'b0;
        else
            r_carry <= o_cout;
    end

endmodule

// File: rtl/serial_counter.sv
// rtl/serial_counter.sv - bit-serial recirculating counter: add/subtract STEP once per word, LSB first
module serial_counter
    import edsac_pkg::*;
#(
    parameter int          WIDTH = 18,
    parameter logic [63:0] STEP  = 64'd1,
    parameter logic [63:0] INIT  = 64'd0
) (
    input  logic             clk,
    input  logic             reset_neg,
    input  logic             d0,
    input  logic             inc_en,
    input  logic             dec,
    input  logic             load,
    input  logic             load_bit,
    input  logic             clr_neg,
    output logic             cntr,
    output logic [WIDTH-1:0] cntr_par,
    output logic             word_done,
    output logic             overflow,
    output logic             zero
);

    localparam logic [WIDTH-1:0] STEP_W    = STEP[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_W    = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_HOT0  = WIDTH'(1);
    localparam slot_t            LAST_SLOT = slot_t'(WIDTH - 1);

    slot_t            r_slot;
    slot_t            w_slot;
    mode_t            r_mode;
    mode_t            w_mode;
    logic             w_first;
    logic             w_last;
    logic             w_store_bit;
    logic             w_a;
    logic             w_b;
    logic             w_cin0;
    logic             w_sum;
    logic             w_cout;
    logic             w_wbit;
    logic [WIDTH-1:0] w_step_sh;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] r_par;
    logic             r_done;
    logic             r_ovf;
    logic             r_zero;

    assign w_slot    = d0 ? '0 : r_slot;
    assign w_first   = (w_slot == '0);
    assign w_last    = (w_slot == LAST_SLOT);
    // Controls are taken live at slot 0 so the first bit already uses the new mode.
    assign w_mode    = w_first ? decode_mode(inc_en, dec, load, clr_neg) : r_mode;
    assign w_step_sh = STEP_W >> w_slot;

    always_comb begin
        w_a    = w_store_bit;
        w_b    = 1'b0;
        w_cin0 = 1'b0;
        case (w_mode)
            MODE_INC: w_b = w_step_sh[0];
            MODE_DEC: begin
                w_b    = ~w_step_sh[0];
                w_cin0 = 1'b1;
            end
            MODE_LOAD, MODE_CLR: w_a = 1'b0;
            default: ;
        endcase
    end

    serial_full_adder u_adder (
        .clk          (clk),
        .reset_neg    (reset_neg),
        .i_a          (w_a),
        .i_b          (w_b),
        .i_preset     (w_first),
        .i_preset_val (w_cin0),
        .o_sum        (w_sum),
        .o_cout       (w_cout)
    );

    assign w_wbit = ((w_mode == MODE_LOAD) ? load_bit : w_sum) & (w_mode != MODE_CLR);
    assign w_mask = ONE_HOT0 << w_slot;
    assign w_word = (r_asm & ~w_mask) | (w_wbit ? w_mask : '0);

    delay_line #(.INTERVAL(WIDTH), .INIT(INIT)) u_store (
        .clk       (clk),
        .reset_neg (reset_neg),
        .i_sync    (d0),
        .i_din     (w_wbit),
        .o_dout    (w_store_bit)
    );

    delay_line #(.INTERVAL(1), .INIT(64'd0)) u_cntr_dly (
        .clk       (clk),
        .reset_neg (reset_neg),
        .i_sync    (1'b0),
        .i_din     (w_wbit),
        .o_dout    (cntr)
    );

    // Only a word that reaches its last slot publishes; a d0-truncated word never does.
    always_ff @(posedge clk or negedge reset_neg) begin
        if (!reset_neg) begin
            r_slot <= '0;
            r_mode <= MODE_IDLE;
            r_asm  <= '0;
            r_par  <= INIT_W;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= (INIT_W == '0);
        end else begin
            r_slot <= w_last ? '0 : w_slot + slot_t'(1);
            r_mode <= w_mode;
            r_asm  <= w_word;
            r_done <= w_last;
            r_ovf  <= w_last & (((w_mode == MODE_INC) & w_cout) |
                                ((w_mode == MODE_DEC) & ~w_cout));
            if (w_last) begin
                r_par  <= w_word;
                r_zero <= (w_word == '0);
            end
        end
    end

    assign cntr_par  = r_par;
    assign word_done = r_done;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_serial_counter.sv
// tb/tb_serial_counter.sv - directed self-checking bench for serial_counter (STEP=1 and STEP=5 instances)
module tb_serial_counter;

    logic        clk = 1'b0;
    logic        reset_neg = 1'b0;
    logic        d0 = 1'b0;
    logic        inc_en = 1'b0;
    logic        dec = 1'b0;
    logic        load = 1'b0;
    logic        load_bit = 1'b0;
    logic        clr_neg = 1'b1;

    logic        cntr, word_done, overflow, zero;
    logic [17:0] cntr_par;
    logic        cntr5, word_done5, overflow5, zero5;
    logic [17:0] cntr_par5;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt, done5_cnt, ovf_cnt, ovf5_cnt;
    logic        cntr_any;
    logic [17:0] cntr_word, cntr5_word;

    always #5 clk = ~clk;

    serial_counter #(.WIDTH(18), .STEP(64'd1), .INIT(64'd0)) dut (
        .clk(clk), .reset_neg(reset_neg), .d0(d0), .inc_en(inc_en), .dec(dec),
        .load(load), .load_bit(load_bit), .clr_neg(clr_neg), .cntr(cntr),
        .cntr_par(cntr_par), .word_done(word_done), .overflow(overflow), .zero(zero)
    );

    serial_counter #(.WIDTH(18), .STEP(64'd5), .INIT(64'd0)) dut5 (
        .clk(clk), .reset_neg(reset_neg), .d0(d0), .inc_en(inc_en), .dec(dec),
        .load(load), .load_bit(load_bit), .clr_neg(clr_neg), .cntr(cntr5),
        .cntr_par(cntr_par5), .word_done(word_done5), .overflow(overflow5), .zero(zero5)
    );

    // Drives nslots slot-cycles starting with d0; from slot chg onwards inc_en/dec take ie2/dc2.
    task automatic do_word(input logic ie, input logic dc, input logic ld, input logic cn,
                           input logic [17:0] ldval, input logic ie2, input logic dc2,
                           input int chg, input int nslots);
        done_cnt = 0; done5_cnt = 0; ovf_cnt = 0; ovf5_cnt = 0;
        cntr_any = 1'b0; cntr_word = '0; cntr5_word = '0;
        for (int k = 0; k < nslots; k++) begin
            d0       = (k == 0);
            inc_en   = (k < chg) ? ie : ie2;
            dec      = (k < chg) ? dc : dc2;
            load     = ld;
            clr_neg  = cn;
            load_bit = ldval[k];
            @(posedge clk); #1;
            done_cnt  += int'(word_done);
            done5_cnt += int'(word_done5);
            ovf_cnt   += int'(overflow);
            ovf5_cnt  += int'(overflow5);
            cntr_any   = cntr_any | cntr;
            cntr_word[k]  = cntr;
            cntr5_word[k] = cntr5;
        end
    endtask

    task automatic test_reset;
        reset_neg = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cntr !== 1'b0) begin errors++; $display("FAIL reset_cntr got %b expected 0", cntr); end
        checks++; if (cntr_par !== 18'h0) begin errors++; $display("FAIL reset_par got %h expected 0", cntr_par); end
        checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", word_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b expected 0", overflow); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b expected 1", zero); end
        checks++; if (zero5 !== 1'b1) begin errors++; $display("FAIL reset_zero5 got %b expected 1", zero5); end
        reset_neg = 1'b1;
    endtask

    task automatic test_count;
        for (int w = 1; w <= 3; w++) begin
            do_word(1, 0, 0, 1, 18'h0, 1, 0, 18, 18);
            checks++; if (cntr_par !== 18'(w)) begin errors++; $display("FAIL count_par%0d got %h expected %h", w, cntr_par, 18'(w)); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL count_done%0d got %0d expected 1", w, done_cnt); end
            checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL count_ovf%0d got %0d expected 0", w, ovf_cnt); end
            checks++; if (cntr_word !== 18'(w)) begin errors++; $display("FAIL count_serial%0d got %h expected %h", w, cntr_word, 18'(w)); end
            if (w == 1) begin
                checks++; if (zero !== 1'b0) begin errors++; $display("FAIL count_zero got %b expected 0", zero); end
            end
        end
        checks++; if (cntr_par5 !== 18'd15) begin errors++; $display("FAIL count_par_step5 got %h expected 0000f", cntr_par5); end
        checks++; if (done5_cnt != 1) begin errors++; $display("FAIL count_done_step5 got %0d expected 1", done5_cnt); end
    endtask

    task automatic test_wrap;
        do_word(0, 0, 1, 1, 18'h3FFFF, 0, 0, 18, 18);
        checks++; if (cntr_par !== 18'h3FFFF) begin errors++; $display("FAIL wrap_load got %h expected 3ffff", cntr_par); end
        checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL wrap_load_ovf got %0d expected 0", ovf_cnt); end
        do_word(1, 0, 0, 1, 18'h0, 1, 0, 18, 18);
        checks++; if (cntr_par !== 18'h0) begin errors++; $display("FAIL wrap_par got %h expected 0", cntr_par); end
        checks++; if (ovf_cnt != 1) begin errors++; $display("FAIL wrap_ovf got %0d expected 1", ovf_cnt); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL wrap_zero got %b expected 1", zero); end
    endtask

    task automatic test_dec;
        do_word(0, 0, 1, 1, 18'h0, 0, 0, 18, 18);
        checks++; if (cntr_par5 !== 18'h0) begin errors++; $display("FAIL dec_load got %h expected 0", cntr_par5); end
        do_word(1, 1, 0, 1, 18'h0, 1, 1, 18, 18);
        checks++; if (cntr_par5 !== 18'h3FFFB) begin errors++; $display("FAIL dec1_par5 got %h expected 3fffb", cntr_par5); end
        checks++; if (ovf5_cnt != 1) begin errors++; $display("FAIL dec1_ovf5 got %0d expected 1", ovf5_cnt); end
        checks++; if (cntr5_word !== 18'h3FFFB) begin errors++; $display("FAIL dec1_serial5 got %h expected 3fffb", cntr5_word); end
        checks++; if (cntr_par !== 18'h3FFFF) begin errors++; $display("FAIL dec1_par got %h expected 3ffff", cntr_par); end
        checks++; if (ovf_cnt != 1) begin errors++; $display("FAIL dec1_ovf got %0d expected 1", ovf_cnt); end
        do_word(1, 1, 0, 1, 18'h0, 1, 1, 18, 18);
        checks++; if (cntr_par5 !== 18'h3FFF6) begin errors++; $display("FAIL dec2_par5 got %h expected 3fff6", cntr_par5); end
        checks++; if (ovf5_cnt != 0) begin errors++; $display("FAIL dec2_ovf5 got %0d expected 0", ovf5_cnt); end
        checks++; if (cntr_par !== 18'h3FFFE) begin errors++; $display("FAIL dec2_par got %h expected 3fffe", cntr_par); end
    endtask

    task automatic test_toggle;
        do_word(0, 0, 1, 1, 18'h0007F, 0, 0, 18, 18);
        do_word(1, 0, 0, 1, 18'h0, 0, 1, 7, 18);
        checks++; if (cntr_par !== 18'h00080) begin errors++; $display("FAIL toggle_add got %h expected 00080", cntr_par); end
        checks++; if (cntr_par5 !== 18'h00084) begin errors++; $display("FAIL toggle_add5 got %h expected 00084", cntr_par5); end
        do_word(1, 1, 0, 1, 18'h0, 1, 0, 7, 18);
        checks++; if (cntr_par !== 18'h0007F) begin errors++; $display("FAIL toggle_sub got %h expected 0007f", cntr_par); end
    endtask

    task automatic test_clear;
        do_word(0, 0, 1, 1, 18'h2AAAA, 0, 0, 18, 18);
        checks++; if (cntr_par !== 18'h2AAAA) begin errors++; $display("FAIL clear_preload got %h expected 2aaaa", cntr_par); end
        checks++; if (cntr_word !== 18'h2AAAA) begin errors++; $display("FAIL clear_preload_serial got %h expected 2aaaa", cntr_word); end
        do_word(1, 0, 1, 0, 18'h3FFFF, 1, 0, 18, 18);
        checks++; if (cntr_par !== 18'h0) begin errors++; $display("FAIL clear_par got %h expected 0", cntr_par); end
        checks++; if (cntr_any !== 1'b0) begin errors++; $display("FAIL clear_serial got %b expected 0", cntr_any); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL clear_zero got %b expected 1", zero); end
        checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL clear_ovf got %0d expected 0", ovf_cnt); end
    endtask

    task automatic test_truncate;
        do_word(0, 0, 1, 1, 18'h2A5FF, 0, 0, 18, 18);
        do_word(1, 0, 0, 1, 18'h0, 1, 0, 18, 9);
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL trunc_done got %0d expected 0", done_cnt); end
        checks++; if (cntr_par !== 18'h2A5FF) begin errors++; $display("FAIL trunc_par_held got %h expected 2a5ff", cntr_par); end
        do_word(0, 0, 0, 1, 18'h0, 0, 0, 18, 18);
        checks++; if (cntr_par !== 18'h2A400) begin errors++; $display("FAIL trunc_result got %h expected 2a400", cntr_par); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL trunc_next_done got %0d expected 1", done_cnt); end
        checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL trunc_ovf got %0d expected 0", ovf_cnt); end
    endtask

    task automatic test_reset_mid;
        do_word(1, 0, 0, 1, 18'h0, 1, 0, 18, 5);
        reset_neg = 1'b0;
        #1;
        checks++; if (cntr_par !== 18'h0) begin errors++; $display("FAIL rstmid_par got %h expected 0", cntr_par); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rstmid_zero got %b expected 1", zero); end
        checks++; if (cntr !== 1'b0) begin errors++; $display("FAIL rstmid_cntr got %b expected 0", cntr); end
        checks++; if (word_done !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL rstmid_pulses got %b%b expected 00", word_done, overflow);
        end
        @(posedge clk); #1;
        reset_neg = 1'b1;
        do_word(1, 0, 0, 1, 18'h0, 1, 0, 18, 18);
        checks++; if (cntr_par !== 18'h1) begin errors++; $display("FAIL rstmid_restart got %h expected 00001", cntr_par); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_restart_done got %0d expected 1", done_cnt); end
    endtask

    initial begin
        test_reset;
        test_count;
        test_wrap;
        test_dec;
        test_toggle;
        test_clear;
        test_truncate;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_counter.md
Name: serial_counter

Overview:
- Parametrised, bit-serial recirculating counter. Generalises the control-section half-minor-cycle counter.
- Holds one WIDTH-bit word in a delay-line store, LSB first. Adds or subtracts a programmable STEP once per word period.
- Adds a serial load, a clear, a per-word control latch, and carry/borrow, zero and parallel-snapshot outputs.
- Sits in the control section beside the memory tank timing. Serves as the tank/half-minor-cycle counter and as a general order counter.

Parameters:
- WIDTH, 18, word length in bits; also the store delay length. Legal range 2..64.
- STEP, 1, constant added or subtracted per word. Width WIDTH; taken modulo 2^WIDTH.
- INIT, 0, store contents after reset.

Ports:
- clk  in  1  system clock; one bit slot per cycle.
- reset_neg  in  1  asynchronous, active-low reset.
- d0  in  1  word-sync digit pulse; the current cycle is bit slot 0 (LSB).
- inc_en  in  1  count enable for the next word.
- dec  in  1  1 = subtract STEP, 0 = add STEP.
- load  in  1  replace the word with the serial load_bit stream.
- load_bit  in  1  serial load data, LSB first, aligned to the slots.
- clr_neg  in  1  active-low synchronous clear of the word being written.
- cntr  out  1  serial counter value, delayed one cycle from the store input.
- cntr_par  out  WIDTH  parallel snapshot of the last completed word.
- word_done  out  1  one-cycle pulse when cntr_par updates.
- overflow  out  1  one-cycle pulse: carry out (add) or borrow (subtract) of the last word.
- zero  out  1  level: last completed word equals 0.

Behaviour:
- Reset (reset_neg low, asynchronous):
  - Store = INIT.
  - slot = 0, carry = 0, control latch = 0.
  - cntr = 0, cntr_par = INIT, word_done = 0, overflow = 0.
  - zero = (INIT == 0).
- Slot counter:
  - Advances 0..WIDTH-1 and wraps.
  - d0 high forces the current cycle to be slot 0; the next cycle is slot 1. A d0 arriving mid-word truncates that word (see below).
  - Without d0 the slot counter free-runs.
- Control latch:
  - At slot 0, inc_en, dec, load and clr_neg are sampled and held for the whole word.
  - Changes of these inputs mid-word have no effect until the next slot 0.
- Per-slot datapath (one full-adder step per cycle). a = store output bit.
  - load: the written bit is load_bit; the adder is bypassed; carry is held at 0.
  - inc_en & !dec: b = STEP[slot]; carry-in at slot 0 = 0.
  - inc_en & dec: b = ~STEP[slot]; carry-in at slot 0 = 1 (two's complement).
  - !inc_en: b = 0; carry-in = 0. The word recirculates unchanged.
  - Written bit = sum & latched clr_neg. Clear has priority over load and count.
  - Carry register updates every slot and is forced to the carry-in value at slot 0.
- Store:
  - WIDTH-cycle delay. A bit written at slot k reappears at slot k of the next word.
- Latency:
  - cntr equals the written bit one cycle later.
  - At the cycle after slot WIDTH-1: cntr_par gets the assembled word, word_done pulses, zero updates, and overflow pulses if the final carry is 1 (add) or 0 (subtract).
  - overflow never pulses for load, clear or idle words.
- Wrap-around:
  - Add from 2^WIDTH-1 gives 0 with overflow.
  - Subtract from 0 gives 2^WIDTH-1 with overflow.
- Truncated word (d0 before slot WIDTH-1):
  - Bits already written stay; the remaining slots keep their old store contents.
  - No word_done, no overflow; the carry is discarded.
- Reset mid-word: all state returns to reset values immediately. The first word after release starts at the next d0 or at free-run slot 0.

Decomposition:
- Shared package edsac_pkg holds:
  - the slot index type (clog2 WIDTH);
  - the mode constants MODE_IDLE, MODE_INC, MODE_DEC, MODE_LOAD, MODE_CLR as a 3-bit typedef.
- Sub-module serial_full_adder: sum, registered carry, synchronous carry preset to a given value.
- The store and the cntr output use the existing delay block (INTERVAL = WIDTH and INTERVAL = 1).

Test Plan:
- Reset with INIT=0, then inc_en=1, dec=0, STEP=1, 3 words -> cntr_par 1, 2, 3; word_done once per word; zero falls after word 1.
- WIDTH=18, load 0x3FFFF, then one inc word -> cntr_par=0, overflow pulses once, zero=1.
- Load 0, then dec with STEP=5 -> cntr_par=0x3FFFB, overflow=1; next dec -> 0x3FFF6, overflow=0.
- Toggle inc_en and dec at slot 7 of a counting word -> that word still adds STEP; the new mode applies from the next slot 0.
- clr_neg=0 together with load=1 and inc_en=1 -> cntr_par=0; cntr stays 0 for the whole word.
- Assert d0 at slot 9 of a word, and separately pulse reset_neg low at slot 5 -> truncation: no word_done, upper bits unchanged; reset: all outputs at reset values within the same cycle, count restarts at INIT.
